count_enable_controller: RTL and testbench
==========================================

Name: count_enable_controller

Overview:
Upstream control stage for the 4-bit synchronous counter. It generates the counter's count_enable pulses at a programmable rate and drives the counter's clear. It sequences start/stop/hold/single-step requests and stops automatically after a programmed number of counts. The counter clears and counts on the same clk edge that this block's registered outputs are sampled on.

Parameters:
DIV_W, 8, width of prescale divisor input div
CNT_W, 4, width of issued-pulse counter and limit; matches counter width

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-low reset
start  in  1  one-cycle request: clear counter and begin counting
stop  in  1  one-cycle request: abort to IDLE, counter value kept
hold  in  1  level: pause counting while high
step  in  1  one-cycle request: issue one pulse while paused
div  in  DIV_W  enable period minus one (pulse every div+1 clocks)
limit  in  CNT_W  pulses to issue before DONE; 0 = free-run
count_enable  out  1  registered enable to counter, one-cycle pulses
counter_clear  out  1  registered active-low clear to counter
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
done  out  1  high while state==DONE

Behaviour:
- Reset (clear low at an edge): state=IDLE, count_enable=0, counter_clear=0, prescaler pc=0, issued=0, done=0. counter_clear returns to 1 at the first edge with clear high.
- Priority when requests coincide: clear > stop > start > hold > step.
- IDLE/DONE + start: next edge gives state=RUN, counter_clear=0 for exactly one cycle, pc=div, issued=0, count_enable=0.
- start in RUN or PAUSE is ignored.
- RUN, hold=0: if pc==0, then pc<=div, count_enable<=1, issued<=issued+1 (mod 2^CNT_W). Otherwise pc<=pc-1 and count_enable<=0.
- First pulse is high during cycle div+1 after start is sampled. div=0 gives count_enable continuously high.
- RUN + hold=1: state=PAUSE, count_enable<=0, pc frozen.
- PAUSE + hold=0: state=RUN, and the prescaler resumes from its frozen pc, so phase is preserved.
- PAUSE + step: count_enable<=1 for one cycle, issued+1, pc unchanged. A step held high gives one pulse per cycle.
- Limit reached (limit!=0): when a pulse makes issued==limit, the next state is DONE. That pulse is still emitted, and count_enable<=0 afterwards.
- limit==0: free-run; issued wraps 15→0 with no DONE.
- stop in RUN/PAUSE: next edge gives state=IDLE, count_enable=0, counter_clear stays 1 (counter holds its value).
- stop in IDLE/DONE: no effect.
- div and limit are sampled continuously. A change takes effect at the next pc reload or the next limit compare.
- DONE: outputs idle; only start or clear leaves DONE.

Optional Feature:
COUNT_ENABLE_CONTROLLER_STEP_EN
- Defined: step behaves as above.
- Undefined: step port remains present but is ignored. PAUSE only exits via hold=0, stop, or clear.

Decomposition:
- Shared package holds state encodings (IDLE/RUN/PAUSE/DONE) and the default DIV_W/CNT_W constants.
- One natural sub-module, enable_prescaler. It holds the pc down-counter with load/freeze/tick outputs. The FSM and issued counter stay in the top module.

Test Plan:
- Reset: clear=0 for 2 cycles during RUN → state=0, count_enable=0, counter_clear=0. One cycle after release → counter_clear=1.
- div=2, limit=5, start pulse → counter_clear low 1 cycle; count_enable pulses on cycles 3,6,9,12,15 after start; then state=3, done=1, downstream Q=5.
- div=0, limit=0, start → count_enable high every cycle for 40 cycles, no DONE, downstream Q wraps 15→0 twice.
- div=3, hold raised 2 cycles after a pulse for 5 cycles → state=2, no pulses. After release, next pulse arrives 2 cycles later (phase kept).
- PAUSE with limit=2, issued=1, step pulse (macro defined) → one count_enable pulse, then DONE. Macro undefined → no pulse, stays PAUSE.
- RUN with stop and start in the same cycle → IDLE, counter_clear stays 1, no pulses. Subsequent start → clear pulse and restart.

Source files
------------

// File: rtl/count_enable_controller_pkg.sv
// Shared definitions for the count-enable controller: FSM state encodings
// and the default parameter widths used by the interface and the top.
package count_enable_controller_pkg;

  localparam int DEFAULT_DIV_W = 8;
  localparam int DEFAULT_CNT_W = 4;
  localparam int STATE_W       = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_enable_controller_if.sv
// Request/configuration/status bundle between a sequencer (master) and the
// count-enable controller (slave). clk and clear stay outside the bundle.
interface count_enable_controller_if
  import count_enable_controller_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic               start;
  logic               stop;
  logic               hold;
  logic               step;
  logic [DIV_W-1:0]   div;
  logic [CNT_W-1:0]   limit;
  logic               count_enable;
  logic               counter_clear;
  logic [STATE_W-1:0] state;
  logic               done;

  modport master (
    output start, stop, hold, step, div, limit,
    input  count_enable, counter_clear, state, done
  );

  modport slave (
    input  start, stop, hold, step, div, limit,
    output count_enable, counter_clear, state, done
  );

endinterface

// File: rtl/count_enable_controller_enable_prescaler.sv
// Prescaler down-counter for the count-enable controller. It reloads from
// div on load, counts down on advance (reloading when it reaches zero), and
// holds its value otherwise, so a pause freezes the enable phase.
module enable_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             advance,
  input  logic [DIV_W-1:0] div,
  output logic             zero
);

  logic [DIV_W-1:0] pc;

  // Down-counter with explicit load, free-running reload at zero, and freeze
  always_ff @(posedge clk) begin
    if (!clear) begin
      pc <= '0;
    end else if (load) begin
      pc <= div;
    end else if (advance) begin
      if (pc == '0) begin
        pc <= div;
      end else begin
        pc <= pc - 1'b1;
      end
    end
  end

  assign zero = (pc == '0);

endmodule

// File: rtl/count_enable_controller.sv
// Count-enable controller: sequences start/stop/hold/step requests and emits
// prescaled one-cycle count_enable pulses plus an active-low counter clear to
// a downstream 4-bit counter, stopping in DONE after limit pulses.
// Optional feature macro: COUNT_ENABLE_CONTROLLER_STEP_EN enables single-step
// pulses while paused; without it the step input is ignored.
module count_enable_controller
  import count_enable_controller_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input logic                       clk,
  input logic                       clear,
  count_enable_controller_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic             enable_q;
  logic             enable_next;
  logic             clear_q;
  logic             clear_next;
  logic             done_q;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] issued_next;
  logic [CNT_W-1:0] issued_inc;
  logic             load;
  logic             advance;
  logic             pulse;
  logic             pc_zero;
  logic             step_req;

`ifdef COUNT_ENABLE_CONTROLLER_STEP_EN
  assign step_req = bus.step;
`else
  logic unused_step;
  assign unused_step = bus.step;
  assign step_req    = 1'b0;
`endif

  assign issued_inc = issued + 1'b1;

  enable_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .clear   (clear),
    .load    (load),
    .advance (advance),
    .div     (bus.div),
    .zero    (pc_zero)
  );

  // Next-state decode; the edge that releases a pause already runs the
  // prescaler so the total delay equals exactly the number of paused cycles
  always_comb begin
    state_next  = state;
    enable_next = 1'b0;
    clear_next  = 1'b1;
    issued_next = issued;
    load        = 1'b0;
    advance     = 1'b0;
    pulse       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next  = RUN;
          clear_next  = 1'b0;
          issued_next = '0;
          load        = 1'b1;
        end
      end
      RUN, PAUSE: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (bus.hold) begin
          state_next = PAUSE;
          if (state == PAUSE) begin
            pulse = step_req;
          end
        end else begin
          state_next = RUN;
          advance    = 1'b1;
          pulse      = pc_zero;
        end
      end
    endcase
    if (pulse) begin
      enable_next = 1'b1;
      issued_next = issued_inc;
      if ((bus.limit != '0) && (issued_inc == bus.limit)) begin
        state_next = DONE;
      end
    end
  end

  // FSM state, issued counter and all registered outputs
  always_ff @(posedge clk) begin
    if (!clear) begin
      state    <= IDLE;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      issued   <= '0;
    end else begin
      state    <= state_next;
      enable_q <= enable_next;
      clear_q  <= clear_next;
      done_q   <= (state_next == DONE);
      issued   <= issued_next;
    end
  end

  assign bus.count_enable  = enable_q;
  assign bus.counter_clear = clear_q;
  assign bus.state         = state;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_count_enable_controller.sv
// Directed testbench for count_enable_controller with a model of the
// downstream 4-bit counter driven by count_enable/counter_clear.
module tb_count_enable_controller;

  logic clk;
  logic clear;
  logic [3:0] q;
  int passed;
  int total;

  count_enable_controller_if #(.DIV_W(8), .CNT_W(4)) bus ();

  count_enable_controller #(.DIV_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter: synchronous active-low clear, counts on enable
  always @(posedge clk) begin
    if (!bus.counter_clear) q <= 4'd0;
    else if (bus.count_enable) q <= q + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    tick();
    tick();
    if (bus.state !== 2'd0) begin total++; $display("[TB] FAIL reset_state: got %0d expected 0", bus.state); end else begin total++; passed++; end
    if (bus.counter_clear !== 1'b0) begin total++; $display("[TB] FAIL reset_cc: got %0d expected 0", bus.counter_clear); end else begin total++; passed++; end
    clear = 1'b1; bus.start = 1'b1; bus.div = 8'd1; bus.limit = 4'd0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    tick();
    tick();
    chk("reset_run_state", bus.state, 0);
    chk("reset_run_ce", bus.count_enable, 0);
    chk("reset_run_cc", bus.counter_clear, 0);
    chk("reset_run_done", bus.done, 0);
    clear = 1'b1;
    tick();
    chk("reset_release_cc", bus.counter_clear, 1);
    chk("reset_release_state", bus.state, 0);
  endtask

  task automatic test_limit();
    bus.div = 8'd2; bus.limit = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("limit_start_cc", bus.counter_clear, 0);
    chk("limit_start_state", bus.state, 1);
    chk("limit_start_ce", bus.count_enable, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) chk("limit_cc_back", bus.counter_clear, 1);
      chk($sformatf("limit_ce_k%0d", k), bus.count_enable, (k % 3 == 0) ? 1 : 0);
      chk($sformatf("limit_state_k%0d", k), bus.state, (k == 15) ? 3 : 1);
    end
    chk("limit_done", bus.done, 1);
    tick();
    chk("limit_after_ce", bus.count_enable, 0);
    chk("limit_q", q, 5);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("limit_stop_in_done", bus.state, 3);
    chk("limit_done_hold", bus.done, 1);
  endtask

  task automatic test_free_run();
    int wraps;
    logic [3:0] prev;
    bus.div = 8'd0; bus.limit = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wraps = 0;
    prev = q;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("free_ce_k%0d", k), bus.count_enable, 1);
      if (k % 10 == 0) chk($sformatf("free_state_k%0d", k), bus.state, 1);
      if (prev == 4'd15 && q == 4'd0) wraps++;
      prev = q;
    end
    chk("free_done", bus.done, 0);
    chk("free_q", q, 7);
    chk("free_wraps", wraps, 2);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("free_stop_state", bus.state, 0);
    chk("free_stop_ce", bus.count_enable, 0);
    chk("free_stop_cc", bus.counter_clear, 1);
  endtask

  task automatic test_hold();
    bus.div = 8'd3; bus.limit = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("hold_pre_ce_k%0d", k), bus.count_enable, (k == 4) ? 1 : 0);
    end
    tick();
    chk("hold_e5_ce", bus.count_enable, 0);
    bus.hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_pause_state_%0d", k), bus.state, 2);
      chk($sformatf("hold_pause_ce_%0d", k), bus.count_enable, 0);
    end
    bus.hold = 1'b0;
    tick();
    chk("hold_release_state", bus.state, 1);
    chk("hold_release_ce", bus.count_enable, 0);
    tick();
    chk("hold_r1_ce", bus.count_enable, 0);
    tick();
    chk("hold_r2_ce", bus.count_enable, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("hold_stop_state", bus.state, 0);
  endtask

  task automatic test_step();
    bus.div = 8'd0; bus.limit = 4'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("step_first_pulse", bus.count_enable, 1);
    bus.hold = 1'b1;
    tick();
    chk("step_paused", bus.state, 2);
    chk("step_paused_ce", bus.count_enable, 0);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
`ifdef COUNT_ENABLE_CONTROLLER_STEP_EN
    chk("step_pulse_ce", bus.count_enable, 1);
    chk("step_pulse_state", bus.state, 3);
    tick();
    chk("step_after_ce", bus.count_enable, 0);
    chk("step_after_done", bus.done, 1);
`else
    chk("step_pulse_ce", bus.count_enable, 0);
    chk("step_pulse_state", bus.state, 2);
    tick();
    chk("step_after_ce", bus.count_enable, 0);
    chk("step_after_state", bus.state, 2);
`endif
    bus.hold = 1'b0; bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("step_cleanup_ce", bus.count_enable, 0);
  endtask

  task automatic test_stop_start();
    bus.div = 8'd1; bus.limit = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("ss_pulse_e4", bus.count_enable, 1);
    chk("ss_q_e4", q, 1);
    bus.stop = 1'b1; bus.start = 1'b1;
    tick();
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("ss_state", bus.state, 0);
    chk("ss_ce", bus.count_enable, 0);
    chk("ss_cc", bus.counter_clear, 1);
    tick();
    tick();
    chk("ss_hold_q", q, 2);
    chk("ss_hold_ce", bus.count_enable, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ss_restart_cc", bus.counter_clear, 0);
    chk("ss_restart_state", bus.state, 1);
    tick();
    chk("ss_restart_q", q, 0);
    chk("ss_restart_cc_back", bus.counter_clear, 1);
  endtask

  initial begin
    passed = 0;
    total = 0;
    clear = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.step = 1'b0;
    bus.div = 8'd0; bus.limit = 4'd0;
    test_reset();
    test_limit();
    test_free_run();
    test_hold();
    test_step();
    test_stop_start();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
